poly_evaluator: RTL

Sequential polynomial evaluator that sits directly downstream of the plot controller, in the function-generator slot. It holds the user-entered coefficients A–E plus the scale registers N and S, loaded from the switches under `select_in`. On each `start` it evaluates A·x⁴+B·x³+C·x²+D·x+E with Horner's method, using one multiply-add per cycle, for the degree given on `calculate`. The result is scaled, converted to an unsigned VGA row, and flagged `out_of_bounds` when it falls off-screen.

---
 rtl/poly_pkg.sv | 32 +++
 rtl/signed_mac.sv | 14 +
 rtl/poly_evaluator.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial evaluator: register select codes,
// controller state encoding and screen geometry.
package poly_pkg;

  // Switch register select codes, also used by the plot controller.
  typedef enum logic [2:0] {
    LOAD_NONE = 3'b000,
    LOAD_A    = 3'b001,
    LOAD_B    = 3'b010,
    LOAD_C    = 3'b011,
    LOAD_D    = 3'b100,
    LOAD_E    = 3'b101,
    LOAD_N    = 3'b110,
    LOAD_S    = 3'b111
  } sel_e;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    SCALE,
    FINISH
  } state_e;

  localparam int Y_MAX    = 240;
  localparam int Y_CENTER = 120;

  // Degrees above 4 have no top coefficient; treat them as a constant.
  function automatic logic [2:0] clamp_degree(input logic [2:0] calc);
    return (calc > 3'd4) ? 3'd0 : calc;
  endfunction

endpackage

// File: rtl/signed_mac.sv
// Combinational signed multiply-add, acc * m + c, wrapping at ACC_W bits.
module signed_mac #(
  parameter int unsigned ACC_W = 48
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic signed [ACC_W-1:0] mul_i,
  input  logic signed [ACC_W-1:0] add_i,
  output logic signed [ACC_W-1:0] res_o
);

  // Context width is ACC_W, so the product keeps only its low ACC_W bits.
  assign res_o = acc_i * mul_i + add_i;

endmodule

// File: rtl/poly_evaluator.sv
// Horner-method polynomial evaluator for the function-generator slot.
// Coefficients A..E and scale registers N/S are level-loaded from switches;
// each start evaluates the selected-degree polynomial, scales it by N and
// 2^-S, and converts the result to a VGA row with an off-screen flag.
module poly_evaluator
  import poly_pkg::*;
#(
  parameter int unsigned COEF_W = 8,
  parameter int unsigned ACC_W  = 48
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [COEF_W-1:0] data_in,
  input  logic [2:0]               select_in,
  input  logic [2:0]               calculate,
  input  logic signed [7:0]        x_val,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               y,
  output logic                     out_of_bounds
);

  localparam logic signed [ACC_W-1:0] YHi = ACC_W'(Y_CENTER);
  localparam logic signed [ACC_W-1:0] YLo = ACC_W'(Y_CENTER - Y_MAX + 1);

  // User registers; index 0..4 = A..E.
  logic signed [COEF_W-1:0] coef_q [5];
  logic signed [COEF_W-1:0] n_q;
  logic [3:0]               s_q;

  // Working copies taken at start so later switch writes cannot disturb
  // an evaluation already in flight.
  logic signed [COEF_W-1:0] run_coef_q [5];
  logic signed [COEF_W-1:0] run_n_q;
  logic [3:0]               run_s_q;

  state_e                   state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [7:0]        x_q;
  logic [2:0]               cnt_q;
  logic [2:0]               idx_q;

  logic [2:0]               deg;
  logic [2:0]               top_idx;
  logic signed [ACC_W-1:0]  mac_mul;
  logic signed [ACC_W-1:0]  mac_add;
  logic signed [ACC_W-1:0]  mac_res;
  logic signed [ACC_W-1:0]  shifted;
  logic                     oob_next;
  logic [7:0]               y_next;

  assign deg     = clamp_degree(calculate);
  assign top_idx = 3'd4 - deg;

  // Level load of the selected register whenever no evaluation is running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        coef_q[i] <= '0;
      end
      n_q <= COEF_W'(1);
      s_q <= '0;
    end else if (!busy) begin
      case (sel_e'(select_in))
        LOAD_A:  coef_q[0] <= data_in;
        LOAD_B:  coef_q[1] <= data_in;
        LOAD_C:  coef_q[2] <= data_in;
        LOAD_D:  coef_q[3] <= data_in;
        LOAD_E:  coef_q[4] <= data_in;
        LOAD_N:  n_q       <= data_in;
        LOAD_S:  s_q       <= data_in[3:0];
        default: ;
      endcase
    end
  end

  // One multiplier serves both Horner steps (x, coefficient) and scaling (N, 0).
  always_comb begin
    mac_mul = ACC_W'(run_n_q);
    mac_add = '0;
    if (state_q == MAC) begin
      mac_mul = ACC_W'(x_q);
      mac_add = ACC_W'(run_coef_q[idx_q]);
    end
  end

  signed_mac #(
    .ACC_W (ACC_W)
  ) u_mac (
    .acc_i (acc_q),
    .mul_i (mac_mul),
    .add_i (mac_add),
    .res_o (mac_res)
  );

  // Final shift, bounds test and conversion from graph y to screen row.
  always_comb begin
    shifted  = acc_q >>> run_s_q;
    oob_next = (shifted > YHi) || (shifted < YLo);
    y_next   = 8'(YHi - shifted);
  end

  // Evaluation controller with registered status and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      x_q           <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      for (int i = 0; i < 5; i++) begin
        run_coef_q[i] <= '0;
      end
      run_n_q       <= '0;
      run_s_q       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      y             <= '0;
      out_of_bounds <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q        <= x_val;
            acc_q      <= ACC_W'(coef_q[top_idx]);
            cnt_q      <= deg;
            idx_q      <= top_idx + 3'd1;
            run_coef_q <= coef_q;
            run_n_q    <= n_q;
            run_s_q    <= s_q;
            busy       <= 1'b1;
            state_q    <= (deg == 3'd0) ? SCALE : MAC;
          end
        end
        MAC: begin
          acc_q <= mac_res;
          idx_q <= idx_q + 3'd1;
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= SCALE;
          end
        end
        SCALE: begin
          acc_q   <= mac_res;
          state_q <= FINISH;
        end
        FINISH: begin
          y             <= y_next;
          out_of_bounds <= oob_next;
          done          <= 1'b1;
          busy          <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
